memctrl: RTL and testbench
==========================

# memctrl

Memory interface controller that sits directly downstream of the xr16 datapath. It accepts 16-bit load/store requests and sequences them onto the 8-bit external asynchronous SRAM bus as one or two byte cycles, with a programmable number of strobe wait states. It assembles read bytes into `rdata` and returns a single-cycle `ack` for pipeline release.

## Interface
- `W`, 16, data/address word width
- `WAIT`, 1, extra strobe cycles per byte access, legal range 0..3

- `clk`  in  1  global clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  1  access request; accepted when `req & ~busy`
- `addr`  in  W  byte address of access (from datapath `addr_nxt`)
- `we`  in  1  1 = store, 0 = load
- `word`  in  1  1 = 16-bit access, 0 = byte access
- `wdata`  in  W  store data (byte store uses `wdata[7:0]`)
- `busy`  out  1  controller not idle; requests ignored
- `ack`  out  1  one-cycle pulse: access complete, `rdata` valid
- `rdata`  out  W  load result; byte loads zero-extended
- `xa`  out  W  external SRAM address
- `xd_o`  out  8  external write data
- `xd_oe`  out  1  external data bus output enable
- `xd_i`  in  8  external read data
- `ram_oe_n`  out  1  SRAM output enable, active low
- `ram_we_n`  out  1  SRAM write enable, active low

## Operation
- Byte order big-endian: even address = bits 15:8, odd = bits 7:0.
- Word access forces `addr[0]=0`; first byte at `addr&~1` (MSB), second at `addr|1` (LSB). Byte access uses `addr` as given.
- On accept: `addr`, `we`, `word`, `wdata` registered; request inputs not sampled again until idle.
- FSM states: IDLE, SETUP, STROBE.
  - IDLE -> SETUP on accept.
  - SETUP (1 cycle): `xa` driven, strobes high; writes drive `xd_o` with `xd_oe=1`.
  - STROBE (WAIT+1 cycles, 2-bit down-counter): `ram_oe_n=0` (load) or `ram_we_n=0` (store); `xa`, `xd_o`, `xd_oe` held stable.
  - At the last STROBE edge: loads capture `xd_i` into the byte lane.
  - If word and first byte: -> SETUP for second byte (`xa|1`). Otherwise -> IDLE with `ack=1` next cycle.
- Byte load: `rdata = {8'h00, byte}`. Word load: `rdata = {msb, lsb}`, updated only at completion. `rdata` holds until the next load completes; stores leave `rdata` unchanged.
- `xd_oe=0` throughout loads and in IDLE. `ram_oe_n` and `ram_we_n` never both low.
- `busy = (state != IDLE)`. `req` arriving while busy is ignored; the requester holds `req` until accepted.

## Timing
- Reset values: state IDLE, `busy=0`, `ack=0`, `rdata=0`, `xa=0`, `xd_o=0`, `xd_oe=0`, `ram_oe_n=1`, `ram_we_n=1`, wait counter 0.
- Latency, from accept edge to `ack` high: byte = WAIT+2 cycles; word = 2*(WAIT+2). With WAIT=1: byte 3, word 6.
- The `ack` cycle is IDLE (`busy=0`). A `req` present in that cycle is accepted at its end, giving zero dead cycles between back-to-back accesses.
- Word store: one SETUP cycle with `ram_we_n=1` separates the two byte strobes, providing address/data hold.
- `rst` asserted in any state: at the next edge all strobes return high, `xd_oe=0`, and no `ack` is issued. The partial access is abandoned and a partial write may have occurred.
- `WAIT=0`: exactly one STROBE cycle per byte.

## Test plan
- Byte load, WAIT=1, `addr=0x1235`, `xd_i=0xA5` -> `xa=0x1235`, `ram_oe_n` low 2 cycles, `ack` 3 cycles after accept, `rdata=0x00A5`.
- Word load, `addr=0x0101`, bytes 0x12 then 0x34 -> `xa` 0x0100 then 0x0101, `ack` at cycle 6, `rdata=0x1234`; `rdata` unchanged before `ack`.
- Word store 0xBEEF to 0x2000 -> 0xBE at 0x2000, then 0xEF at 0x2001; `ram_we_n` low 2 cycles each with a high gap between; `ram_oe_n=1` throughout; `xd_oe=1` only in SETUP/STROBE.
- Back-to-back: `req` held through a byte load's `ack` cycle -> second access enters SETUP the cycle after `ack`; `req` during busy produces no extra access.
- Reset in the STROBE of the first byte of a word store -> strobes high and `xd_oe=0` next edge, `busy=0`, no `ack`, all outputs at reset values.
- WAIT=0 byte store 0x00C3 to 0x0007 -> `xd_o=0xC3`, `ram_we_n` low 1 cycle, `ack` 2 cycles after accept.

Source files
------------

// File: rtl/memctrl.sv
// memctrl: sequences 16-bit load/store requests onto an 8-bit async SRAM bus.
// Latency: accept edge to ack is WAIT+2 cycles per byte (byte WAIT+2, word 2*(WAIT+2)).
// Backpressure: busy=1 while not IDLE; req is ignored until idle, requester holds req.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req/addr/we/word/wdata request side (from datapath), sampled on accept only
//   busy, ack, rdata      status and load result (ack is a one-cycle pulse)
//   xa, xd_o, xd_oe, xd_i external SRAM address/data bus
//   ram_oe_n, ram_we_n    external SRAM strobes, active low
module memctrl #(
  parameter int W    = 16,
  parameter int WAIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic [W-1:0] addr,
  input  logic         we,
  input  logic         word,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         ack,
  output logic [W-1:0] rdata,
  output logic [W-1:0] xa,
  output logic [7:0]   xd_o,
  output logic         xd_oe,
  input  logic [7:0]   xd_i,
  output logic         ram_oe_n,
  output logic         ram_we_n
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2
  } state_e;

  localparam logic [1:0] WAIT_CNT = 2'(WAIT);

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         we_q, we_d;
  logic         word_q, word_d;
  logic         second_q, second_d;   // currently on the LSB half of a word access
  logic [7:0]   lo_q, lo_d;           // store data for the second byte of a word store
  logic [7:0]   msb_q, msb_d;         // first byte of a word load, held until completion
  logic [W-1:0] rdata_q, rdata_d;
  logic         ack_q, ack_d;
  logic [W-1:0] xa_q, xa_d;
  logic [7:0]   xd_o_q, xd_o_d;
  logic         xd_oe_q, xd_oe_d;
  logic         oe_n_q, oe_n_d;
  logic         we_n_q, we_n_d;

  // Strobes and bus drivers are registered so the async SRAM never sees
  // decode glitches; they change on the same edge as the state they belong to.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    word_d   = word_q;
    second_d = second_q;
    lo_d     = lo_q;
    msb_d    = msb_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    xa_d     = xa_q;
    xd_o_d   = xd_o_q;
    xd_oe_d  = xd_oe_q;
    oe_n_d   = oe_n_q;
    we_n_d   = we_n_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d  = S_SETUP;
          we_d     = we;
          word_d   = word;
          second_d = 1'b0;
          lo_d     = wdata[7:0];
          // Word accesses start at the even (MSB) byte.
          xa_d     = word ? {addr[W-1:1], 1'b0} : addr;
          xd_o_d   = word ? wdata[15:8] : wdata[7:0];
          xd_oe_d  = we;
        end
      end

      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = WAIT_CNT;
        oe_n_d  = we_q;
        we_n_d  = ~we_q;
      end

      S_STROBE: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          oe_n_d = 1'b1;
          we_n_d = 1'b1;
          if (!we_q) begin
            if (word_q && !second_q) msb_d = xd_i;
            else if (word_q)         rdata_d = W'({msb_q, xd_i});
            else                     rdata_d = W'(xd_i);
          end
          if (word_q && !second_q) begin
            // Back through SETUP: gives address/data hold between byte strobes.
            state_d  = S_SETUP;
            second_d = 1'b1;
            xa_d     = {xa_q[W-1:1], 1'b1};
            xd_o_d   = lo_q;
          end else begin
            state_d = S_IDLE;
            ack_d   = 1'b1;
            xd_oe_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        xd_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      we_q     <= 1'b0;
      word_q   <= 1'b0;
      second_q <= 1'b0;
      lo_q     <= 8'h00;
      msb_q    <= 8'h00;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      xa_q     <= '0;
      xd_o_q   <= 8'h00;
      xd_oe_q  <= 1'b0;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      word_q   <= word_d;
      second_q <= second_d;
      lo_q     <= lo_d;
      msb_q    <= msb_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      xa_q     <= xa_d;
      xd_o_q   <= xd_o_d;
      xd_oe_q  <= xd_oe_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign xa       = xa_q;
  assign xd_o     = xd_o_q;
  assign xd_oe    = xd_oe_q;
  assign ram_oe_n = oe_n_q;
  assign ram_we_n = we_n_q;

endmodule

// File: tb/tb_memctrl.sv
// tb_memctrl: directed tests of memctrl with WAIT=1 (instance a) and WAIT=0 (instance b).
// A tiny combinational SRAM model answers reads by address.
module tb_memctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance a: WAIT=1
  logic        a_req, a_we, a_word, a_busy, a_ack, a_xd_oe, a_oe_n, a_we_n;
  logic [15:0] a_addr, a_wdata, a_rdata, a_xa;
  logic [7:0]  a_xd_o, a_xd_i;
  // Instance b: WAIT=0
  logic        b_req, b_we, b_word, b_busy, b_ack, b_xd_oe, b_oe_n, b_we_n;
  logic [15:0] b_addr, b_wdata, b_rdata, b_xa;
  logic [7:0]  b_xd_o, b_xd_i;

  memctrl #(.W(16), .WAIT(1)) u_a (
    .clk(clk), .rst(rst), .req(a_req), .addr(a_addr), .we(a_we), .word(a_word),
    .wdata(a_wdata), .busy(a_busy), .ack(a_ack), .rdata(a_rdata), .xa(a_xa),
    .xd_o(a_xd_o), .xd_oe(a_xd_oe), .xd_i(a_xd_i), .ram_oe_n(a_oe_n), .ram_we_n(a_we_n)
  );

  memctrl #(.W(16), .WAIT(0)) u_b (
    .clk(clk), .rst(rst), .req(b_req), .addr(b_addr), .we(b_we), .word(b_word),
    .wdata(b_wdata), .busy(b_busy), .ack(b_ack), .rdata(b_rdata), .xa(b_xa),
    .xd_o(b_xd_o), .xd_oe(b_xd_oe), .xd_i(b_xd_i), .ram_oe_n(b_oe_n), .ram_we_n(b_we_n)
  );

  function automatic logic [7:0] sram(input logic [15:0] a);
    case (a)
      16'h1235: sram = 8'hA5;
      16'h0100: sram = 8'h12;
      16'h0101: sram = 8'h34;
      default:  sram = 8'h5A;
    endcase
  endfunction

  assign a_xd_i = sram(a_xa);
  assign b_xd_i = sram(b_xa);

  // Observation mux so one monitor task serves both instances.
  logic        sel;
  logic        m_busy, m_ack, m_xd_oe, m_oe_n, m_we_n;
  logic [15:0] m_rdata, m_xa;
  logic [7:0]  m_xd_o;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_ack   = sel ? b_ack   : a_ack;
  assign m_xd_oe = sel ? b_xd_oe : a_xd_oe;
  assign m_oe_n  = sel ? b_oe_n  : a_oe_n;
  assign m_we_n  = sel ? b_we_n  : a_we_n;
  assign m_rdata = sel ? b_rdata : a_rdata;
  assign m_xa    = sel ? b_xa    : a_xa;
  assign m_xd_o  = sel ? b_xd_o  : a_xd_o;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-access statistics gathered by run_access.
  int          acc_n, oe_low, we_low, oe_hi, both_low, rd_chg, nlog;
  logic [15:0] pat;
  logic [15:0] log_xa [4];
  logic [7:0]  log_xd [4];

  // Called in the cycle right after the accept edge; runs until ack (bounded).
  task automatic run_access();
    logic [15:0] prev_rd;
    logic        prev_low, low;
    acc_n = 0; oe_low = 0; we_low = 0; oe_hi = 0; both_low = 0; rd_chg = 0; nlog = 0;
    pat = '0;
    prev_rd = m_rdata;
    prev_low = 1'b0;
    while (!m_ack && acc_n < 20) begin
      tick();
      acc_n++;
      low = ~m_oe_n | ~m_we_n;
      pat = {pat[14:0], low};
      if (!m_oe_n) oe_low++;
      if (!m_we_n) we_low++;
      if (!m_oe_n && !m_we_n) both_low++;
      if (m_xd_oe) oe_hi++;
      if (!m_ack && m_rdata !== prev_rd) rd_chg++;
      if (low && !prev_low && nlog < 4) begin
        log_xa[nlog] = m_xa;
        log_xd[nlog] = m_xd_o;
        nlog++;
      end
      prev_low = low;
    end
  endtask

  initial begin
    int acks;
    sel = 1'b0;
    rst = 1'b1;
    a_req = 0; a_we = 0; a_word = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_word = 0; b_addr = '0; b_wdata = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy",  a_busy,  0);
    check("rst_ack",   a_ack,   0);
    check("rst_rdata", a_rdata, 16'h0000);
    check("rst_xa",    a_xa,    16'h0000);
    check("rst_xd_o",  a_xd_o,  8'h00);
    check("rst_xd_oe", a_xd_oe, 0);
    check("rst_oe_n",  a_oe_n,  1);
    check("rst_we_n",  a_we_n,  1);

    // Byte load 0x1235 -> 0x00A5
    a_req = 1; a_addr = 16'h1235; a_we = 0; a_word = 0;
    tick();
    a_req = 0;
    check("bl_busy", a_busy, 1);
    check("bl_xa",   a_xa,   16'h1235);
    check("bl_setup_oe_n", a_oe_n, 1);
    run_access();
    check("bl_lat",    acc_n,   3);
    check("bl_oe_low", oe_low,  2);
    check("bl_we_low", we_low,  0);
    check("bl_xd_oe",  oe_hi,   0);
    check("bl_rdata",  a_rdata, 16'h00A5);
    check("bl_ack_busy", a_busy, 0);
    tick();
    check("bl_ack_pulse", a_ack, 0);

    // Word load 0x0101 -> bytes at 0x0100, 0x0101
    a_req = 1; a_addr = 16'h0101; a_we = 0; a_word = 1;
    tick();
    a_req = 0;
    check("wl_xa0", a_xa, 16'h0100);
    run_access();
    check("wl_lat",    acc_n,    6);
    check("wl_pat",    pat,      16'h0036);
    check("wl_nlog",   nlog,     2);
    check("wl_xa_a",   log_xa[0], 16'h0100);
    check("wl_xa_b",   log_xa[1], 16'h0101);
    check("wl_rd_chg", rd_chg,   0);
    check("wl_rdata",  a_rdata,  16'h1234);

    // Word store 0xBEEF -> 0x2000/0x2001
    a_req = 1; a_addr = 16'h2000; a_we = 1; a_word = 1; a_wdata = 16'hBEEF;
    tick();
    a_req = 0;
    check("ws_setup_xd_oe", a_xd_oe, 1);
    check("ws_setup_we_n",  a_we_n,  1);
    run_access();
    check("ws_lat",    acc_n,     6);
    check("ws_pat",    pat,       16'h0036);
    check("ws_we_low", we_low,    4);
    check("ws_oe_low", oe_low,    0);
    check("ws_both",   both_low,  0);
    check("ws_xd_oe",  oe_hi,     5);
    check("ws_nlog",   nlog,      2);
    check("ws_xa_a",   log_xa[0], 16'h2000);
    check("ws_xd_a",   log_xd[0], 8'hBE);
    check("ws_xa_b",   log_xa[1], 16'h2001);
    check("ws_xd_b",   log_xd[1], 8'hEF);
    check("ws_rdata",  a_rdata,   16'h1234);
    check("ws_ack_xd_oe", a_xd_oe, 0);

    // Back-to-back: req held throughout; inputs changed while busy must be ignored
    a_req = 1; a_addr = 16'h1235; a_we = 0; a_word = 0;
    tick();
    a_addr = 16'h0101; a_word = 1;
    run_access();
    check("bb1_lat",   acc_n,     3);
    check("bb1_xa",    log_xa[0], 16'h1235);
    check("bb1_rdata", a_rdata,   16'h00A5);
    a_addr = 16'h0100; a_word = 0;
    tick();
    a_req = 0;
    check("bb2_busy", a_busy, 1);
    check("bb2_xa",   a_xa,   16'h0100);
    run_access();
    check("bb2_lat",   acc_n,   3);
    check("bb2_rdata", a_rdata, 16'h0012);
    tick(); tick(); tick();
    check("bb_idle", a_busy, 0);

    // Reset during first-byte STROBE of a word store
    a_req = 1; a_addr = 16'h2000; a_we = 1; a_word = 1; a_wdata = 16'hBEEF;
    tick();
    a_req = 0;
    tick();
    check("rs_strobe", a_we_n, 0);
    rst = 1;
    tick();
    rst = 0;
    check("rs_we_n",  a_we_n,  1);
    check("rs_oe_n",  a_oe_n,  1);
    check("rs_xd_oe", a_xd_oe, 0);
    check("rs_busy",  a_busy,  0);
    check("rs_xa",    a_xa,    16'h0000);
    check("rs_xd_o",  a_xd_o,  8'h00);
    check("rs_rdata", a_rdata, 16'h0000);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_ack) acks++;
      tick();
    end
    check("rs_no_ack", acks, 0);
    check("rs_idle",   a_busy, 0);

    // WAIT=0 byte store 0x00C3 -> 0x0007
    sel = 1'b1;
    b_req = 1; b_addr = 16'h0007; b_we = 1; b_word = 0; b_wdata = 16'h00C3;
    tick();
    b_req = 0;
    check("w0_xa",    b_xa,    16'h0007);
    check("w0_xd_o",  b_xd_o,  8'hC3);
    check("w0_xd_oe", b_xd_oe, 1);
    run_access();
    check("w0_lat",    acc_n,     2);
    check("w0_we_low", we_low,    1);
    check("w0_oe_low", oe_low,    0);
    check("w0_log_xd", log_xd[0], 8'hC3);
    check("w0_rdata",  b_rdata,   16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
